// File: rtl/ysyx_22050612_decode_stage.sv
// ysyx_22050612_decode_stage
// ---------------------------------------------------------------------------
// Registered RV32I/RV64I decode stage sitting between fetch and execute.
// One instruction word plus its PC is accepted over a valid/ready handshake,
// decoded combinationally (format, register indices, immediate, rd write
// enable, illegal flag) and captured into a one-entry output register.
// The output register supports back-pressure (out_ready) and flush.
// A 32-bit counter tracks instructions handed to execute.
//
// Parameters
//   XLEN        datapath width, 32 or 64 (W-opcodes legal only when 64)
//
// Ports
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   flush       drop the held instruction and any incoming one
//   in_valid / in_ready / in_inst / in_pc      fetch-side handshake
//   out_valid / out_ready                      execute-side handshake
//   out_pc, out_opcode, out_funct3, out_funct7,
//   out_rd, out_rs1, out_rs2, out_imm,
//   out_fmt, out_rd_wen, out_illegal           registered decode fields
//   out_count   number of delivered instructions (wraps)
// ---------------------------------------------------------------------------
module ysyx_22050612_decode_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_rd_wen,
    output logic            out_illegal,
    output logic [31:0]     out_count
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_e;

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    // ------------------------------------------------------------------
    // Combinational decode of the incoming word
    // ------------------------------------------------------------------
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [2:0]      dec_fmt;
    logic [31:0]     dec_imm32;
    logic [XLEN-1:0] dec_imm;
    logic            dec_legal;
    logic            dec_rd_wen;

    assign opcode = in_inst[6:0];
    assign rd     = in_inst[11:7];

    always_comb begin
        dec_fmt = FMT_ILL;
        unique case (opcode)
            7'b0110011:                       dec_fmt = FMT_R;
            7'b0111011: if (XLEN == 64)       dec_fmt = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111,
            7'b1110011, 7'b0001111:           dec_fmt = FMT_I;
            7'b0011011: if (XLEN == 64)       dec_fmt = FMT_I;
            7'b0100011:                       dec_fmt = FMT_S;
            7'b1100011:                       dec_fmt = FMT_B;
            7'b0110111, 7'b0010111:           dec_fmt = FMT_U;
            7'b1101111:                       dec_fmt = FMT_J;
            default:                          dec_fmt = FMT_ILL;
        endcase
        // Every listed opcode already ends in 2'b11; kept as an explicit guard
        // so compressed-space words can never slip through an edited table.
        if (in_inst[1:0] != 2'b11) begin
            dec_fmt = FMT_ILL;
        end
    end

    assign dec_legal = (dec_fmt != FMT_ILL);

    // Immediates are assembled as 32-bit signed values and then widened, so
    // the same expressions serve both XLEN settings.
    always_comb begin
        dec_imm32 = 32'd0;
        unique case (dec_fmt)
            FMT_I:   dec_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            FMT_S:   dec_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            FMT_B:   dec_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                                  in_inst[30:25], in_inst[11:8], 1'b0};
            FMT_U:   dec_imm32 = {in_inst[31:12], 12'd0};
            FMT_J:   dec_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                                  in_inst[20], in_inst[30:21], 1'b0};
            default: dec_imm32 = 32'd0;
        endcase
    end

    assign dec_imm = XLEN'($signed(dec_imm32));

    // Stores, branches and fences never write a destination register.
    assign dec_rd_wen = dec_legal && (rd != 5'd0) &&
                        (opcode != 7'b0100011) &&
                        (opcode != 7'b1100011) &&
                        (opcode != 7'b0001111);

    // ------------------------------------------------------------------
    // Handshake control
    // ------------------------------------------------------------------
    state_e state_q, state_d;
    logic   accept;
    logic   deliver;
    logic   count_en;

    assign out_valid = (state_q == S_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready && !flush;
    assign deliver   = out_valid && out_ready;
    // A flushed instruction is discarded, not delivered.
    assign count_en  = deliver && !flush;

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_EMPTY;
        end else if (accept) begin
            state_d = S_FULL;
        end else if (deliver) begin
            state_d = S_EMPTY;
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    logic [XLEN-1:0] pc_q;
    logic [31:0]     inst_q;
    logic [XLEN-1:0] imm_q;
    logic [2:0]      fmt_q;
    logic            rd_wen_q;
    logic            illegal_q;
    logic [31:0]     count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_EMPTY;
            pc_q      <= '0;
            inst_q    <= '0;
            imm_q     <= '0;
            fmt_q     <= 3'd0;
            rd_wen_q  <= 1'b0;
            illegal_q <= 1'b0;
            count_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                pc_q      <= in_pc;
                inst_q    <= in_inst;
                imm_q     <= dec_imm;
                fmt_q     <= dec_fmt;
                rd_wen_q  <= dec_rd_wen;
                illegal_q <= !dec_legal;
            end
            if (count_en) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    assign out_pc      = pc_q;
    assign out_opcode  = inst_q[6:0];
    assign out_funct3  = inst_q[14:12];
    assign out_funct7  = inst_q[31:25];
    assign out_rd      = inst_q[11:7];
    assign out_rs1     = inst_q[19:15];
    assign out_rs2     = inst_q[24:20];
    assign out_imm     = imm_q;
    assign out_fmt     = fmt_q;
    assign out_rd_wen  = rd_wen_q;
    assign out_illegal = illegal_q;
    assign out_count   = count_q;

endmodule

// File: tb/tb_ysyx_22050612_decode_stage.sv
// Testbench for ysyx_22050612_decode_stage: an XLEN=64 instance checked by a
// delivery scoreboard, plus an XLEN=32 instance sharing the same stimulus for
// the W-opcode legality case.
module tb_ysyx_22050612_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_inst = 32'd0;
    logic [63:0] in_pc = 64'd0;
    logic        out_ready = 1'b0;

    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [63:0] out_imm;
    logic [2:0]  out_fmt;
    logic        out_rd_wen, out_illegal;
    logic [31:0] out_count;

    logic        in_ready32, out_valid32;
    logic [31:0] out_pc32;
    logic [6:0]  out_opcode32;
    logic [2:0]  out_funct3_32;
    logic [6:0]  out_funct7_32;
    logic [4:0]  out_rd32, out_rs1_32, out_rs2_32;
    logic [31:0] out_imm32;
    logic [2:0]  out_fmt32;
    logic        out_rd_wen32, out_illegal32;
    logic [31:0] out_count32;

    always #5 clk = ~clk;

    ysyx_22050612_decode_stage #(.XLEN(64)) u64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_rd_wen(out_rd_wen), .out_illegal(out_illegal),
        .out_count(out_count)
    );

    ysyx_22050612_decode_stage #(.XLEN(32)) u32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_inst(in_inst), .in_pc(in_pc[31:0]),
        .out_valid(out_valid32), .out_ready(out_ready), .out_pc(out_pc32),
        .out_opcode(out_opcode32), .out_funct3(out_funct3_32), .out_funct7(out_funct7_32),
        .out_rd(out_rd32), .out_rs1(out_rs1_32), .out_rs2(out_rs2_32), .out_imm(out_imm32),
        .out_fmt(out_fmt32), .out_rd_wen(out_rd_wen32), .out_illegal(out_illegal32),
        .out_count(out_count32)
    );

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
        logic [2:0]  fmt;
        logic [63:0] imm;
        logic        rd_wen;
        logic        illegal;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_count = 32'd0;

    // Scoreboard: every delivery (valid && ready, no flush) pops one entry.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !flush) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL deliver_unexpected: got pc=%h inst-op=%b, required no delivery", out_pc, out_opcode);
            end else begin
                mon_e = sb.pop_front();
                $display("deliver pc=%h fmt=%0d imm=%h rd=%0d rd_wen=%0d illegal=%0d",
                         out_pc, out_fmt, out_imm, out_rd, out_rd_wen, out_illegal);
                if ({out_funct7, out_rs2, out_rs1, out_funct3, out_rd, out_opcode} !== mon_e.inst) begin
                    miscompares++;
                    $display("FAIL fields: got %h, required %h",
                             {out_funct7, out_rs2, out_rs1, out_funct3, out_rd, out_opcode}, mon_e.inst);
                end
                vectors++;
                if (out_pc !== mon_e.pc) begin
                    miscompares++;
                    $display("FAIL pc: got %h, required %h", out_pc, mon_e.pc);
                end
                vectors++;
                if (out_imm !== mon_e.imm) begin
                    miscompares++;
                    $display("FAIL imm: got %h, required %h", out_imm, mon_e.imm);
                end
                vectors++;
                if ({out_fmt, out_rd_wen, out_illegal} !== {mon_e.fmt, mon_e.rd_wen, mon_e.illegal}) begin
                    miscompares++;
                    $display("FAIL fmt/rd_wen/illegal: got %0d/%0d/%0d, required %0d/%0d/%0d",
                             out_fmt, out_rd_wen, out_illegal, mon_e.fmt, mon_e.rd_wen, mon_e.illegal);
                end
            end
        end
    end

    // Drive one instruction and hold it until accepted (called at posedge+1).
    task automatic send(input logic [31:0] inst, input logic [63:0] pc);
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        for (int n = 0; n < 20 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready && !flush;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        vectors++;
        if (!acc) begin
            miscompares++;
            $display("FAIL accept_timeout: got no accept for inst %h, required accept within 20 cycles", inst);
        end
    endtask

    task automatic push_exp(input logic [31:0] inst, input logic [63:0] pc, input logic [2:0] fmt,
                            input logic [63:0] imm, input logic rd_wen, input logic illegal);
        exp_t e;
        e.inst = inst; e.pc = pc; e.fmt = fmt; e.imm = imm; e.rd_wen = rd_wen; e.illegal = illegal;
        sb.push_back(e);
    endtask

    task automatic test_reset;
        #12;
        vectors++;
        if ({out_valid, in_ready, out_count, out_fmt, out_imm, out_pc} !== {1'b0, 1'b1, 32'd0, 3'd0, 64'd0, 64'd0}) begin
            miscompares++;
            $display("FAIL reset_state: got valid=%0d ready=%0d count=%0d fmt=%0d imm=%h pc=%h, required 0/1/0/0/0/0",
                     out_valid, in_ready, out_count, out_fmt, out_imm, out_pc);
        end
        $display("reset state checked");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_decode;
        out_ready = 1'b1;
        push_exp(32'hFFF00093, 64'h1000, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        send(32'hFFF00093, 64'h1000);
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL latency: got out_valid=%0d after accept edge, required 1", out_valid);
        end
        @(posedge clk);
        #1;
        exp_count = exp_count + 32'd1;
        vectors++;
        if ({out_valid, out_count} !== {1'b0, exp_count}) begin
            miscompares++;
            $display("FAIL addi_drain: got valid=%0d count=%0d, required 0/%0d", out_valid, out_count, exp_count);
        end
        // back-to-back: beq, lui, add, sw, jal
        push_exp(32'hFE000EE3, 64'h1004, 3'd3, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0);
        push_exp(32'h800002B7, 64'h1008, 3'd4, 64'hFFFF_FFFF_8000_0000, 1'b1, 1'b0);
        push_exp(32'h002081B3, 64'h100C, 3'd0, 64'd0,                 1'b1, 1'b0);
        push_exp(32'h0020A423, 64'h1010, 3'd2, 64'd8,                 1'b0, 1'b0);
        push_exp(32'hFF9FF06F, 64'h1014, 3'd5, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b0);
        send(32'hFE000EE3, 64'h1004);
        send(32'h800002B7, 64'h1008);
        send(32'h002081B3, 64'h100C);
        send(32'h0020A423, 64'h1010);
        send(32'hFF9FF06F, 64'h1014);
        @(posedge clk);
        #1;
        exp_count = exp_count + 32'd5;
        vectors++;
        if ({out_valid, out_count} !== {1'b0, exp_count}) begin
            miscompares++;
            $display("FAIL b2b_count: got valid=%0d count=%0d, required 0/%0d", out_valid, out_count, exp_count);
        end
    endtask

    task automatic test_illegal;
        out_ready = 1'b1;
        push_exp(32'h00000000, 64'h2000, 3'd7, 64'd0, 1'b0, 1'b1);
        push_exp(32'h0010009B, 64'h2004, 3'd1, 64'd1, 1'b1, 1'b0);
        send(32'h00000000, 64'h2000);
        send(32'h0010009B, 64'h2004);
        vectors++;
        if ({out_valid32, out_fmt32, out_illegal32, out_rd_wen32, out_imm32} !== {1'b1, 3'd7, 1'b1, 1'b0, 32'd0}) begin
            miscompares++;
            $display("FAIL addiw_xlen32: got valid=%0d fmt=%0d illegal=%0d rd_wen=%0d imm=%h, required 1/7/1/0/0",
                     out_valid32, out_fmt32, out_illegal32, out_rd_wen32, out_imm32);
        end
        $display("xlen32 addiw fmt=%0d illegal=%0d", out_fmt32, out_illegal32);
        @(posedge clk);
        #1;
        exp_count = exp_count + 32'd2;
        vectors++;
        if (out_count !== exp_count) begin
            miscompares++;
            $display("FAIL illegal_count: got %0d, required %0d", out_count, exp_count);
        end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b0;
        push_exp(32'h00100093, 64'h3000, 3'd1, 64'd1, 1'b1, 1'b0);
        push_exp(32'h00200113, 64'h3004, 3'd1, 64'd2, 1'b1, 1'b0);
        push_exp(32'h00300193, 64'h3008, 3'd1, 64'd3, 1'b1, 1'b0);
        send(32'h00100093, 64'h3000);
        in_valid = 1'b1;
        in_inst  = 32'h00200113;
        in_pc    = 64'h3004;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            vectors++;
            if ({in_ready, out_valid, out_pc} !== {1'b0, 1'b1, 64'h3000}) begin
                miscompares++;
                $display("FAIL backpressure_hold: got ready=%0d valid=%0d pc=%h, required 0/1/3000",
                         in_ready, out_valid, out_pc);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_inst = 32'h00300193;
        in_pc   = 64'h3008;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        exp_count = exp_count + 32'd3;
        vectors++;
        if ({out_valid, out_count} !== {1'b0, exp_count}) begin
            miscompares++;
            $display("FAIL backpressure_drain: got valid=%0d count=%0d, required 0/%0d", out_valid, out_count, exp_count);
        end
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        send(32'h00500293, 64'h4000);   // held, then flushed: no expectation pushed
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_inst   = 32'h00600313;
        in_pc     = 64'h4004;
        out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_in_ready: got %0d, required 1", in_ready);
        end
        @(posedge clk);
        #1;
        vectors++;
        if ({out_valid, out_count} !== {1'b0, exp_count}) begin
            miscompares++;
            $display("FAIL flush_empty: got valid=%0d count=%0d, required 0/%0d", out_valid, out_count, exp_count);
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_drop: got valid=%0d, required 0", out_valid);
        end
        $display("flush done count=%0d", out_count);
    endtask

    task automatic test_async_reset;
        out_ready = 1'b0;
        send(32'h00700393, 64'h5000);   // lost in reset
        #2;
        rst_n = 1'b0;
        #1;
        exp_count = 32'd0;
        vectors++;
        if ({out_valid, in_ready, out_count, out_pc, out_imm, out_fmt, out_rd, out_rd_wen}
            !== {1'b0, 1'b1, 32'd0, 64'd0, 64'd0, 3'd0, 5'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL async_reset: got valid=%0d ready=%0d count=%0d pc=%h imm=%h fmt=%0d rd=%0d, required all 0 and ready=1",
                     out_valid, in_ready, out_count, out_pc, out_imm, out_fmt, out_rd);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        push_exp(32'hFFF00093, 64'h6000, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        send(32'hFFF00093, 64'h6000);
        @(posedge clk);
        #1;
        exp_count = exp_count + 32'd1;
        vectors++;
        if (out_count !== exp_count) begin
            miscompares++;
            $display("FAIL post_reset_count: got %0d, required %0d", out_count, exp_count);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_illegal();
        test_back_to_back();
        test_flush();
        test_async_reset();
        repeat (2) @(posedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_leftover: got %0d entries, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
